// File: rtl/controller_poll_sequencer_m_if.sv
// Controller poll sequencer bus interface.
//
// Groups the poll handshake (start/busy/done), the controller pin signals
// (shift clock, latch strobe, active-low serial data) and the committed
// button bytes.
//   master : poll requester / pin side (drives start and the data lines)
//   slave  : the sequencer (drives handshake status, pins and button bytes)
interface controller_poll_sequencer_m_if #(
  parameter int unsigned NUM_BITS = 8
) ();
  logic                start;
  logic                busy;
  logic                done;
  logic                controller_clk;
  logic                controller_latch;
  logic                controller_1_data_in_B;
  logic                controller_2_data_in_B;
  logic [NUM_BITS-1:0] controller_1_buttons;
  logic [NUM_BITS-1:0] controller_2_buttons;

  modport master (
    output start,
    output controller_1_data_in_B,
    output controller_2_data_in_B,
    input  busy,
    input  done,
    input  controller_clk,
    input  controller_latch,
    input  controller_1_buttons,
    input  controller_2_buttons
  );

  modport slave (
    input  start,
    input  controller_1_data_in_B,
    input  controller_2_data_in_B,
    output busy,
    output done,
    output controller_clk,
    output controller_latch,
    output controller_1_buttons,
    output controller_2_buttons
  );
endinterface

// File: rtl/controller_poll_sequencer_m.sv
// Game controller poll sequencer.
//
// Drives the shared serial shift-register protocol (latch pulse, then NUM_BITS
// clock pulses), samples both active-low data lines in parallel and commits two
// active-high button bytes atomically in a single cycle, flagged by done.
//
// Ports:
//   clk_12_5875 : system clock, rising edge
//   rst         : synchronous active-high reset
//   bus (slave) : start/busy/done handshake, controller_clk/controller_latch
//                 pins, controller_{1,2}_data_in_B inputs, button byte outputs
//
// Optional feature, macro CONTROLLER_POLL_DEBOUNCE_EN: a controller's button
// byte only updates when two consecutive raw poll results agree.
module controller_poll_sequencer_m #(
  parameter int unsigned HALF_PERIOD        = 6,
  parameter int unsigned LATCH_HALF_PERIODS = 2,
  parameter int unsigned NUM_BITS           = 8
) (
  input  logic                         clk_12_5875,
  input  logic                         rst,
  controller_poll_sequencer_m_if.slave bus
);

  localparam int unsigned LatchCycles = LATCH_HALF_PERIODS * HALF_PERIOD;
  localparam int unsigned CntMax      = (LatchCycles > HALF_PERIOD) ? LatchCycles : HALF_PERIOD;
  localparam int unsigned CntW        = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned BitW        = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [CntW-1:0] LatchLast = CntW'(LatchCycles - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PERIOD - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(NUM_BITS - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StSample, StShift, StCommit} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic                pending_q, pending_d;
  logic [NUM_BITS-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic [NUM_BITS-1:0] btn1_q, btn1_d, btn2_q, btn2_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                latch_q, latch_d, sclk_q, sclk_d;
  logic                sample_en, commit_en;

  // State register.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic; cnt counts cycles within the current phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLatch;
          cnt_d   = '0;
        end
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          state_d = StSample;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        if (cnt_q == HalfLast) begin
          state_d = StShift;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (bit_q == BitLast) begin
            state_d = StCommit;
          end else begin
            state_d = StSample;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        // A request seen during the poll or in this cycle chains straight on.
        if (pending_q || bus.start) begin
          state_d = StLatch;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending request flag and datapath next-state.
  assign sample_en = (state_q == StSample) && (cnt_q == HalfLast);
  assign commit_en = (state_d == StCommit);

  always_comb begin
    pending_d = pending_q;
    if ((state_q != StIdle) && bus.start) begin
      pending_d = 1'b1;
    end
    // Entering LATCH consumes any outstanding request.
    if ((state_d == StLatch) && (state_q != StLatch)) begin
      pending_d = 1'b0;
    end
  end

  // First sampled bit ends up in the MSB after NUM_BITS shifts.
  always_comb begin
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    if (sample_en) begin
      sr1_d = {sr1_q[NUM_BITS-2:0], bus.controller_1_data_in_B};
      sr2_d = {sr2_q[NUM_BITS-2:0], bus.controller_2_data_in_B};
    end
  end

`ifdef CONTROLLER_POLL_DEBOUNCE_EN
  logic [NUM_BITS-1:0] prev1_q, prev1_d, prev2_q, prev2_d;

  always_comb begin
    btn1_d  = btn1_q;
    btn2_d  = btn2_q;
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    if (commit_en) begin
      if (~sr1_q == prev1_q) btn1_d = ~sr1_q;
      if (~sr2_q == prev2_q) btn2_d = ~sr2_q;
      prev1_d = ~sr1_q;
      prev2_d = ~sr2_q;
    end
  end

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      prev1_q <= '0;
      prev2_q <= '0;
    end else begin
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
    end
  end
`else
  always_comb begin
    btn1_d = btn1_q;
    btn2_d = btn2_q;
    if (commit_en) begin
      btn1_d = ~sr1_q;
      btn2_d = ~sr2_q;
    end
  end
`endif

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      pending_q <= 1'b0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      btn1_q    <= '0;
      btn2_q    <= '0;
    end else begin
      pending_q <= pending_d;
      sr1_q     <= sr1_d;
      sr2_q     <= sr2_d;
      btn1_q    <= btn1_d;
      btn2_q    <= btn2_d;
    end
  end

  // Output logic, decoded from the next state so every output is registered.
  always_comb begin
    latch_d = (state_d == StLatch);
    sclk_d  = (state_d == StShift);
    done_d  = (state_d == StCommit);
    // In the COMMIT cycle busy stays high only if a follow-up poll is queued.
    busy_d  = (state_d == StLatch) || (state_d == StSample) || (state_d == StShift) ||
              ((state_d == StCommit) && pending_d);
  end

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      latch_q <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      latch_q <= latch_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.controller_latch     = latch_q;
  assign bus.controller_clk       = sclk_q;
  assign bus.controller_1_buttons = btn1_q;
  assign bus.controller_2_buttons = btn2_q;

endmodule
